ula_multiciclo: RTL and testbench

//  Parametrised, registered ALU: next generation of the 4-bit combinational ULA, generalised to N bits.

---
 rtl/ula_multiciclo.sv | 155 +++++++++++++++
 tb/tb_ula_multiciclo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - registered N-bit ALU with valid/ready handshake and iterative shift-add multiply
module ula_multiciclo #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] r,
    output logic [N-1:0] r_alto,
    output logic         zero,
    output logic         carry,
    output logic         overflow,
    output logic         neg,
    output logic         erro
);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_EQ  = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        LIVRE,
        CALC,
        PRONTO
    } estado_t;

    estado_t          estado;
    logic [2*N-1:0]   mcand;
    logic [2*N-1:0]   acc;
    logic [2*N-1:0]   acc_nx;
    logic [N-1:0]     mplier;
    logic [CW-1:0]    cnt;

    logic [N:0]       soma;
    logic [N:0]       dif;
    logic [N-1:0]     alu_r;
    logic             alu_c;
    logic             alu_v;
    logic             alu_e;

    assign soma = {1'b0, a} + {1'b0, b};
    assign dif  = {1'b0, a} - {1'b0, b};

    // Single-cycle datapath; bit N of dif is the borrow (a < b unsigned).
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        alu_e = 1'b0;
        case (op)
            OP_ADD: begin
                alu_r = soma[N-1:0];
                alu_c = soma[N];
                alu_v = (a[N-1] == b[N-1]) && (soma[N-1] != a[N-1]);
            end
            OP_SUB: begin
                alu_r = dif[N-1:0];
                alu_c = dif[N];
                alu_v = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
            end
            OP_AND: alu_r = a & b;
            OP_OR:  alu_r = a | b;
            OP_XOR: alu_r = a ^ b;
            OP_EQ:  alu_r = {{(N-1){1'b0}}, (a == b)};
            default: alu_e = 1'b1;
        endcase
    end

    assign acc_nx = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= LIVRE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r         <= '0;
            r_alto    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            neg       <= 1'b0;
            erro      <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (estado)
                LIVRE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (op == OP_MUL) begin
                            mcand  <= {{N{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                            estado <= CALC;
                        end else begin
                            r         <= alu_r;
                            r_alto    <= '0;
                            zero      <= (alu_r == '0);
                            carry     <= alu_c;
                            overflow  <= alu_v;
                            neg       <= alu_r[N-1];
                            erro      <= alu_e;
                            out_valid <= 1'b1;
                            estado    <= PRONTO;
                        end
                    end
                end
                CALC: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == ULTIMO) begin
                        r         <= acc_nx[N-1:0];
                        r_alto    <= acc_nx[2*N-1:N];
                        zero      <= (acc_nx[N-1:0] == '0);
                        carry     <= |acc_nx[2*N-1:N];
                        overflow  <= 1'b0;
                        neg       <= acc_nx[N-1];
                        erro      <= 1'b0;
                        out_valid <= 1'b1;
                        estado    <= PRONTO;
                    end
                end
                PRONTO: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        estado    <= LIVRE;
                    end
                end
                default: begin
                    estado    <= LIVRE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - directed-vector bench for ula_multiciclo (N=8)
module tb_ula_multiciclo;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] r;
    logic [N-1:0] r_alto;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         neg;
    logic         erro;

    int vectors = 0;
    int miscompares = 0;

    ula_multiciclo #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .r_alto    (r_alto),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .neg       (neg),
        .erro      (erro)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags = {zero, carry, overflow, neg, erro}
    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] er, input logic [7:0] eh, input logic [4:0] ef, input int elat);
        int lat;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 8'hA5;
        b        = 8'h3C;
        op       = 3'b011;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, ".lat"}, lat, elat);
        check({tag, ".r"}, r, er);
        check({tag, ".r_alto"}, r_alto, eh);
        check({tag, ".flags"}, {zero, carry, overflow, neg, erro}, ef);
        check({tag, ".in_ready_busy"}, in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".in_ready_after"}, in_ready, 1'b1);
        check({tag, ".out_valid_after"}, out_valid, 1'b0);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset.in_ready", in_ready, 1'b1);
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.r", r, 8'd0);
        check("reset.r_alto", r_alto, 8'd0);
        check("reset.flags", {zero, carry, overflow, neg, erro}, 5'b00000);

        run_op("add200_100", 3'b000, 8'd200, 8'd100, 8'd44,  8'd0, 5'b01000, 0);
        run_op("add100_100", 3'b000, 8'd100, 8'd100, 8'd200, 8'd0, 5'b00110, 0);
        run_op("sub5_7",     3'b001, 8'd5,   8'd7,   8'd254, 8'd0, 5'b01010, 0);
        run_op("sub9_9",     3'b001, 8'd9,   8'd9,   8'd0,   8'd0, 5'b10000, 0);
        run_op("sub80_01",   3'b001, 8'h80,  8'h01,  8'h7F,  8'd0, 5'b00100, 0);
        run_op("and",        3'b010, 8'hF0,  8'h3C,  8'h30,  8'd0, 5'b00000, 0);
        run_op("or",         3'b011, 8'hF0,  8'h3C,  8'hFC,  8'd0, 5'b00010, 0);
        run_op("xor",        3'b100, 8'hF0,  8'h3C,  8'hCC,  8'd0, 5'b00010, 0);
        run_op("eq9_9",      3'b101, 8'd9,   8'd9,   8'd1,   8'd0, 5'b00000, 0);
        run_op("eq9_8",      3'b101, 8'd9,   8'd8,   8'd0,   8'd0, 5'b10000, 0);
        run_op("mul15_17",   3'b110, 8'd15,  8'd17,  8'hFF,  8'h00, 5'b00010, N);
        run_op("mul200_3",   3'b110, 8'd200, 8'd3,   8'h58,  8'h02, 5'b01000, N);
        run_op("mulFF_FF",   3'b110, 8'hFF,  8'hFF,  8'h01,  8'hFE, 5'b01000, N);
        run_op("invalid",    3'b111, 8'd1,   8'd1,   8'd0,   8'd0, 5'b10001, 0);

        // Backpressure: result held while out_ready low; stray in_valid ignored.
        op = 3'b000; a = 8'd200; b = 8'd100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp.out_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                op = 3'b000; a = 8'd1; b = 8'd1; in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check("bp.hold_r", r, 8'd44);
            check("bp.hold_flags", {zero, carry, overflow, neg, erro}, 5'b01000);
            check("bp.in_ready", in_ready, 1'b0);
            check("bp.out_valid_held", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.release_in_ready", in_ready, 1'b1);
        check("bp.release_out_valid", out_valid, 1'b0);
        check("bp.release_r_kept", r, 8'd44);
        tick();
        check("bp.no_ghost_op", out_valid, 1'b0);

        // Reset during the third CALC cycle of 200*3.
        op = 3'b110; a = 8'd200; b = 8'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstcalc.in_ready", in_ready, 1'b1);
        check("rstcalc.out_valid", out_valid, 1'b0);
        check("rstcalc.r", r, 8'd0);
        check("rstcalc.r_alto", r_alto, 8'd0);
        seen = 0;
        for (int i = 0; i < 2 * N; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("rstcalc.no_result", seen, 0);

        run_op("post_rst_add", 3'b000, 8'd100, 8'd100, 8'd200, 8'd0, 5'b00110, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
